regwrite_trace_tx: RTL and testbench
====================================

// Module: regwrite_trace_tx
// PURPOSE
//   Sits beside the cpu writeback stage and watches register-file writes.
//   Writes to selected registers ($s0/$s1 by default) are queued and sent out as byte frames on a valid/ready stream.
//   A host-side reader or a bench monitor sees register updates without peeking into the hierarchy.
// PARAMETERS
//   FIFO_DEPTH  4             entries in the capture queue; power of 2, >= 2
//   WATCH_MASK  32'h0003_0000 bit i set => writes to R[i] are traced; bit 0 ignored (R0 never traced)
// PORTS
//   Clk        in   1   system clock, all state updates on posedge
//   Rst        in   1   asynchronous, active-high reset
//   RegWrite   in   1   writeback enable from cpu
//   WriteReg   in   5   destination register index
//   WriteData  in   32  value being written
//   TxData     out  8   current frame byte
//   TxValid    out  1   TxData is valid
//   TxReady    in   1   downstream accepts byte when TxValid && TxReady at posedge Clk
//   Overflow   out  1   sticky: at least one traced write was dropped
//   Busy       out  1   FSM not IDLE or queue non-empty
// BEHAVIOUR
//   Reset (async, Rst=1): TxValid=0, TxData=8'h00, Overflow=0, Busy=0, queue empty, FSM=IDLE, timestamp counter=0.
//   Capture: a qualifying write has RegWrite=1, WriteReg!=0 and WATCH_MASK[WriteReg]=1.
//     - If the queue is not full, the write pushes {WriteReg, WriteData} at that posedge.
//     - Fullness is the pre-edge state. A push against a full queue is dropped even if a pop happens on the same edge.
//     - A drop sets Overflow=1. Overflow stays 1 until reset.
//   Frame: header {3'b101, reg[4:0]}, then data bytes [31:24], [23:16], [15:8], [7:0].
//   FSM states: IDLE, HDR, D3, D2, D1, D0.
//     - IDLE: if the queue is non-empty, pop into the holding register and go to HDR.
//     - HDR..D0: TxValid=1. TxData comes from the holding register. Advance to the next state only on TxValid && TxReady.
//     - While TxReady=0, TxData and TxValid are held stable (no retraction).
//     - On D0 acceptance: if the queue is non-empty, pop and go to HDR (no bubble between frames); else go to IDLE with TxValid=0.
//   Latency: a write at edge N into an empty queue with the FSM in IDLE is popped at edge N+1. The header is valid from N+1 until the end of cycle N+2.
//   Effective capacity is FIFO_DEPTH + 1 (the holding register plus the queue).
//   Queue pointers wrap modulo FIFO_DEPTH. Separate full/empty flags use an extra pointer bit.
//   Rst asserted mid-frame abandons the frame: no residual bytes after release.
// CONFIGURATION
//   Macro REGWRITE_TRACE_TIMESTAMP_EN:
//     - defined: a free-running 16-bit cycle counter (wraps 16'hFFFF -> 0) is stored with each entry at push.
//       The frame becomes 7 bytes: header, TS[15:8], TS[7:0], D3..D0. The FSM adds states T1, T0 between HDR and D3.
//       The header is {3'b111, reg}.
//     - undefined: no counter and no timestamp storage. Frames are 5 bytes and the header is {3'b101, reg}.
// STRUCTURE
//   Package trace_pkg holds:
//     - header prefixes (HDR_PLAIN=3'b101, HDR_TS=3'b111)
//     - the FSM state encoding
//     - the entry width constants (REG_W=5, DATA_W=32, TS_W=16)
//     - frame length constants
//   Sub-module trace_fifo: synchronous FIFO, parameterised by width/depth; push, pop, full, empty.
//   Top level: capture qualifier, holding register, serialiser FSM, Overflow flag.
// TESTING
//   1. Write R16=32'h12345678, TxReady=1 -> bytes B0,12,34,56,78 on consecutive cycles; header valid 1 cycle after the write edge.
//   2. Write R8=32'hFFFFFFFF, then R0 with RegWrite=1 -> no TxValid; Busy stays 0.
//   3. Write R17=32'hCAFEF00D, TxReady low 3 cycles during the D2 byte -> TxData=8'hFE and TxValid=1 held stable; then F0,0D follow.
//   4. R16 written on 6 consecutive cycles with TxReady=0 -> Overflow=1 after the 6th; after TxReady=1, exactly 5 frames arrive in order.
//   5. Rst=1 after 2 bytes of a frame accepted -> TxValid=0 immediately, Overflow=0; after release, no further bytes.
//   6. With REGWRITE_TRACE_TIMESTAMP_EN: write R16=1 at counter 16'h0005 -> bytes F0,00,05,00,00,00,01.
//      Repeat across counter wrap -> timestamp 16'h0000 after 16'hFFFF.

Source files
------------

// File: rtl/regwrite_trace_tx_pkg.sv
// Shared types and constants for the register-write trace transmitter.
// Optional macro REGWRITE_TRACE_TIMESTAMP_EN adds a 16-bit timestamp to every entry.
package trace_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int TS_W   = 16;

    localparam logic [2:0] HDR_PLAIN = 3'b101;
    localparam logic [2:0] HDR_TS    = 3'b111;

    localparam int FRAME_LEN_PLAIN = 5;
    localparam int FRAME_LEN_TS    = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_T1,
        ST_T0,
        ST_D3,
        ST_D2,
        ST_D1,
        ST_D0
    } state_e;

`ifdef REGWRITE_TRACE_TIMESTAMP_EN
    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } entry_t;
    localparam logic [2:0] HDR_PREFIX = HDR_TS;
    localparam int         FRAME_LEN  = FRAME_LEN_TS;
`else
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } entry_t;
    localparam logic [2:0] HDR_PREFIX = HDR_PLAIN;
    localparam int         FRAME_LEN  = FRAME_LEN_PLAIN;
`endif

    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/regwrite_trace_tx_if.sv
// Capture (writeback) and byte-stream signals of the trace transmitter.
interface regwrite_trace_tx_if;
    import trace_pkg::*;

    logic              RegWrite;
    logic [REG_W-1:0]  WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [7:0]        TxData;
    logic              TxValid;
    logic              TxReady;

    modport master (
        output RegWrite, WriteReg, WriteData, TxReady,
        input  TxData, TxValid
    );

    modport slave (
        input  RegWrite, WriteReg, WriteData, TxReady,
        output TxData, TxValid
    );

endinterface

// File: rtl/regwrite_trace_tx_fifo.sv
// Synchronous FIFO; extra pointer bit distinguishes full from empty.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/regwrite_trace_tx.sv
// Traces writes to watched registers and serialises them as byte frames.
// Macro REGWRITE_TRACE_TIMESTAMP_EN: 7-byte frames carrying a 16-bit cycle stamp.
module regwrite_trace_tx
    import trace_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] WATCH_MASK = 32'h0003_0000
) (
    input  logic                 Clk,
    input  logic                 Rst,
    regwrite_trace_tx_if.slave   trace,
    output logic                 Overflow,
    output logic                 Busy
);

    entry_t push_entry, pop_entry, hold;
    logic   qualify, push, pop, full, empty;
    state_e state, state_nxt;

    assign qualify = trace.RegWrite && (trace.WriteReg != '0) && WATCH_MASK[trace.WriteReg];
    assign push    = qualify && !full;
    // Holding register refills straight from D0 so frames run back to back.
    assign pop     = !empty && ((state == ST_IDLE) || (state == ST_D0 && trace.TxReady));
    assign Busy    = (state != ST_IDLE) || !empty;

`ifdef REGWRITE_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) ts_cnt <= '0;
        else     ts_cnt <= ts_cnt + 1'b1;
    end

    assign push_entry = '{ts: ts_cnt, rd: trace.WriteReg, data: trace.WriteData};
`else
    assign push_entry = '{rd: trace.WriteReg, data: trace.WriteData};
`endif

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst   (Rst),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (pop_entry),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            hold     <= '0;
            Overflow <= 1'b0;
        end else begin
            if (pop)
                hold <= pop_entry;
            if (qualify && full)
                Overflow <= 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (!empty) state_nxt = ST_HDR;
`ifdef REGWRITE_TRACE_TIMESTAMP_EN
            ST_HDR:  if (trace.TxReady) state_nxt = ST_T1;
            ST_T1:   if (trace.TxReady) state_nxt = ST_T0;
            ST_T0:   if (trace.TxReady) state_nxt = ST_D3;
`else
            ST_HDR:  if (trace.TxReady) state_nxt = ST_D3;
`endif
            ST_D3:   if (trace.TxReady) state_nxt = ST_D2;
            ST_D2:   if (trace.TxReady) state_nxt = ST_D1;
            ST_D1:   if (trace.TxReady) state_nxt = ST_D0;
            ST_D0:   if (trace.TxReady) state_nxt = empty ? ST_IDLE : ST_HDR;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        trace.TxValid = 1'b1;
        trace.TxData  = 8'h00;
        case (state)
            ST_HDR:  trace.TxData = {HDR_PREFIX, hold.rd};
`ifdef REGWRITE_TRACE_TIMESTAMP_EN
            ST_T1:   trace.TxData = hold.ts[15:8];
            ST_T0:   trace.TxData = hold.ts[7:0];
`endif
            ST_D3:   trace.TxData = hold.data[31:24];
            ST_D2:   trace.TxData = hold.data[23:16];
            ST_D1:   trace.TxData = hold.data[15:8];
            ST_D0:   trace.TxData = hold.data[7:0];
            default: trace.TxValid = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_regwrite_trace_tx.sv
// Randomised and directed bench for regwrite_trace_tx against a byte-queue reference model.
module tb_regwrite_trace_tx;
    import trace_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] WATCH = 32'h0003_0000;
`ifdef REGWRITE_TRACE_TIMESTAMP_EN
    localparam int FLEN = 7;
`else
    localparam int FLEN = 5;
`endif

    logic Clk = 1'b0;
    logic Rst;
    logic Overflow, Busy;

    regwrite_trace_tx_if bus ();

    regwrite_trace_tx #(
        .FIFO_DEPTH (DEPTH),
        .WATCH_MASK (WATCH)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .trace    (bus),
        .Overflow (Overflow),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pending writes plus the bytes still owed for the frame on the wire.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [15:0] ts;
    } ent_t;

    ent_t        pend[$];
    logic [7:0]  cur[$];
    logic [7:0]  acc[$];
    logic        m_ovf;
    logic [15:0] m_cnt;

    function automatic void load(ent_t e);
        cur.delete();
`ifdef REGWRITE_TRACE_TIMESTAMP_EN
        cur.push_back({3'b111, e.rd});
        cur.push_back(e.ts[15:8]);
        cur.push_back(e.ts[7:0]);
`else
        cur.push_back({3'b101, e.rd});
`endif
        cur.push_back(e.data[31:24]);
        cur.push_back(e.data[23:16]);
        cur.push_back(e.data[15:8]);
        cur.push_back(e.data[7:0]);
    endfunction

    function automatic logic exp_valid();
        return cur.size() != 0;
    endfunction

    function automatic logic [7:0] exp_data();
        return (cur.size() != 0) ? cur[0] : 8'h00;
    endfunction

    function automatic logic exp_busy();
        return (cur.size() != 0) || (pend.size() != 0);
    endfunction

    function automatic void model_reset();
        pend.delete();
        cur.delete();
        m_ovf = 1'b0;
        m_cnt = 16'h0000;
    endfunction

    task automatic step(input logic rw, input logic [4:0] wr, input logic [31:0] wd, input logic rdy);
        ent_t e;
        logic was_full;
        bus.RegWrite  = rw;
        bus.WriteReg  = wr;
        bus.WriteData = wd;
        bus.TxReady   = rdy;
        if (bus.TxValid === 1'b1 && rdy)
            acc.push_back(bus.TxData);
        was_full = (pend.size() == DEPTH);
        if (cur.size() == 0) begin
            if (pend.size() != 0) load(pend.pop_front());
        end else if (rdy) begin
            cur.delete(0);
            if (cur.size() == 0 && pend.size() != 0) load(pend.pop_front());
        end
        if (rw && wr != 5'd0 && WATCH[wr]) begin
            if (was_full) m_ovf = 1'b1;
            else begin
                e.rd = wr; e.data = wd; e.ts = m_cnt;
                pend.push_back(e);
            end
        end
        m_cnt = m_cnt + 16'd1;
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.RegWrite  = 1'b0;
        bus.WriteReg  = 5'd0;
        bus.WriteData = 32'd0;
        bus.TxReady   = 1'b0;
        Rst = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        model_reset();
        acc.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        total += 4;
        if (bus.TxValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.TxValid); end
        if (bus.TxData !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus.TxData); end
        if (Overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", Overflow); end
        if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Busy); end
    endtask

    task automatic test_single_frame();
        logic [7:0] want [5];
        want[0] = 8'hB0; want[1] = 8'h12; want[2] = 8'h34; want[3] = 8'h56; want[4] = 8'h78;
        acc.delete();
        step(1'b1, 5'd16, 32'h1234_5678, 1'b1);
        total++;
        if (bus.TxValid !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", bus.TxValid); end
        step(1'b0, 5'd0, 32'd0, 1'b1);
        total++;
`ifdef REGWRITE_TRACE_TIMESTAMP_EN
        if (bus.TxValid !== 1'b1 || bus.TxData !== 8'hF0) begin
`else
        if (bus.TxValid !== 1'b1 || bus.TxData !== 8'hB0) begin
`endif
            bad++; $display("FAIL single_hdr got v=%b d=%h", bus.TxValid, bus.TxData);
        end
        for (int i = 0; i < FLEN + 2; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b1);
            total++;
            if (bus.TxValid !== exp_valid() || bus.TxData !== exp_data()) begin
                bad++; $display("FAIL single_seq cyc=%0d got v=%b d=%h want v=%b d=%h",
                                i, bus.TxValid, bus.TxData, exp_valid(), exp_data());
            end
        end
`ifndef REGWRITE_TRACE_TIMESTAMP_EN
        total++;
        if (acc.size() != 5) begin bad++; $display("FAIL single_count got=%0d want=5", acc.size()); end
        else for (int i = 0; i < 5; i++) begin
            total++;
            if (acc[i] !== want[i]) begin bad++; $display("FAIL single_byte%0d got=%h want=%h", i, acc[i], want[i]); end
        end
`endif
    endtask

    task automatic test_unwatched();
        step(1'b1, 5'd8, 32'hFFFF_FFFF, 1'b1);
        step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.TxValid !== 1'b0 || Busy !== 1'b0) begin
                bad++; $display("FAIL unwatched cyc=%0d got v=%b busy=%b want 0 0", i, bus.TxValid, Busy);
            end
            step(1'b0, 5'd0, 32'd0, 1'b1);
        end
    endtask

    task automatic test_backpressure();
        int guard;
        acc.delete();
        step(1'b1, 5'd17, 32'hCAFE_F00D, 1'b1);
        guard = 0;
        while (cur.size() != 3 && guard < 20) begin
            step(1'b0, 5'd0, 32'd0, 1'b1);
            guard++;
        end
        total++;
        if (guard >= 20) begin bad++; $display("FAIL bp_timeout got=%0d want<20", guard); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b0);
            total++;
            if (bus.TxValid !== 1'b1 || bus.TxData !== 8'hFE) begin
                bad++; $display("FAIL bp_hold cyc=%0d got v=%b d=%h want v=1 d=fe", i, bus.TxValid, bus.TxData);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b1);
            total++;
            if (bus.TxValid !== exp_valid() || bus.TxData !== exp_data()) begin
                bad++; $display("FAIL bp_seq cyc=%0d got v=%b d=%h want v=%b d=%h",
                                i, bus.TxValid, bus.TxData, exp_valid(), exp_data());
            end
        end
        total++;
        if (acc.size() != FLEN || acc[FLEN-3] !== 8'hFE || acc[FLEN-2] !== 8'hF0 || acc[FLEN-1] !== 8'h0D) begin
            bad++; $display("FAIL bp_tail got n=%0d want n=%0d ending fe f0 0d", acc.size(), FLEN);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 5'd16, 32'hA0 + i, 1'b0);
            total++;
            if (Overflow !== (i == 5)) begin
                bad++; $display("FAIL ovf_flag cyc=%0d got=%b want=%b", i, Overflow, (i == 5));
            end
        end
        for (int i = 0; i < 6 * FLEN + 4; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b1);
            total++;
            if (bus.TxValid !== exp_valid() || bus.TxData !== exp_data() || Overflow !== 1'b1) begin
                bad++; $display("FAIL ovf_drain cyc=%0d got v=%b d=%h o=%b want v=%b d=%h o=1",
                                i, bus.TxValid, bus.TxData, Overflow, exp_valid(), exp_data());
            end
        end
        total++;
        if (acc.size() != 5 * FLEN) begin bad++; $display("FAIL ovf_count got=%0d want=%0d", acc.size(), 5 * FLEN); end
        else for (int f = 0; f < 5; f++) begin
            total++;
            if (acc[f*FLEN + FLEN - 1] !== 8'hA0 + f[7:0]) begin
                bad++; $display("FAIL ovf_order frame=%0d got=%h want=%h", f, acc[f*FLEN + FLEN - 1], 8'hA0 + f[7:0]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int guard;
        apply_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 5'd16, 32'h5555_0000 + i, 1'b0);
        acc.delete();
        guard = 0;
        while (acc.size() < 2 && guard < 20) begin
            step(1'b0, 5'd0, 32'd0, 1'b1);
            guard++;
        end
        #1 Rst = 1'b1;
        #1;
        total += 3;
        if (bus.TxValid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", bus.TxValid); end
        if (Overflow !== 1'b0) begin bad++; $display("FAIL midrst_ovf got=%b want=0", Overflow); end
        if (Busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", Busy); end
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        model_reset();
        acc.delete();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b1);
            total++;
            if (bus.TxValid !== 1'b0) begin bad++; $display("FAIL midrst_after cyc=%0d got=%b want=0", i, bus.TxValid); end
        end
        total++;
        if (acc.size() != 0) begin bad++; $display("FAIL midrst_bytes got=%0d want=0", acc.size()); end
    endtask

    task automatic test_random();
        logic [4:0] wr;
        logic       rdy;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 4))
                0: wr = 5'd16;
                1: wr = 5'd17;
                2: wr = 5'd0;
                3: wr = 5'd8;
                default: wr = 5'($urandom);
            endcase
            rdy = (i % 150 < 40) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            step(1'($urandom), wr, $urandom, rdy);
            total++;
            if (bus.TxValid !== exp_valid() || bus.TxData !== exp_data() ||
                Overflow !== m_ovf || Busy !== exp_busy()) begin
                bad++; $display("FAIL rand cyc=%0d got v=%b d=%h o=%b b=%b want v=%b d=%h o=%b b=%b",
                                i, bus.TxValid, bus.TxData, Overflow, Busy,
                                exp_valid(), exp_data(), m_ovf, exp_busy());
            end
        end
    endtask

`ifdef REGWRITE_TRACE_TIMESTAMP_EN
    task automatic test_timestamp();
        logic [7:0] want [7];
        want[0] = 8'hF0; want[1] = 8'h00; want[2] = 8'h05; want[3] = 8'h00;
        want[4] = 8'h00; want[5] = 8'h00; want[6] = 8'h01;
        apply_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 32'd0, 1'b1);
        step(1'b1, 5'd16, 32'd1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 5'd0, 32'd0, 1'b1);
        total++;
        if (acc.size() != 7) begin bad++; $display("FAIL ts_count got=%0d want=7", acc.size()); end
        else for (int i = 0; i < 7; i++) begin
            total++;
            if (acc[i] !== want[i]) begin bad++; $display("FAIL ts_byte%0d got=%h want=%h", i, acc[i], want[i]); end
        end
        while (m_cnt != 16'hFFFF) step(1'b0, 5'd0, 32'd0, 1'b1);
        acc.delete();
        step(1'b1, 5'd16, 32'd2, 1'b1);
        step(1'b1, 5'd17, 32'd3, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b1);
            total++;
            if (bus.TxValid !== exp_valid() || bus.TxData !== exp_data()) begin
                bad++; $display("FAIL ts_wrap_seq cyc=%0d got v=%b d=%h want v=%b d=%h",
                                i, bus.TxValid, bus.TxData, exp_valid(), exp_data());
            end
        end
        total++;
        if (acc.size() != 14 || acc[1] !== 8'hFF || acc[2] !== 8'hFF || acc[8] !== 8'h00 || acc[9] !== 8'h00) begin
            bad++; $display("FAIL ts_wrap got n=%0d want n=14 stamps ffff then 0000", acc.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_unwatched();
        test_backpressure();
        test_overflow();
        test_mid_reset();
        test_random();
`ifdef REGWRITE_TRACE_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
